// File: rtl/bpu_bimodal.sv
// Bimodal branch predictor: direct-mapped BTB with 2-bit saturating counters,
// combinational fetch lookup, registered EX-side update and statistics counters.
module bpu_bimodal #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          i_fetch_pc,
  output logic                 o_pred_taken,
  output logic [31:0]          o_pred_target,
  input  logic                 i_upd_valid,
  input  logic [31:0]          i_upd_pc,
  input  logic                 i_upd_is_jump,
  input  logic                 i_upd_taken,
  input  logic [31:0]          i_upd_target,
  input  logic                 i_upd_mispred,
  output logic [CNT_WIDTH-1:0] o_upd_cnt,
  output logic [CNT_WIDTH-1:0] o_mispred_cnt
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  jump_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic                  fetch_hit;

  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  logic                  upd_taken_eff;
  logic                  upd_write;
  logic [1:0]            nxt_ctr;
  logic                  nxt_jump;
  logic [31:0]           nxt_target;

  // Word-alignment bits of both PCs carry no information for the BTB.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{i_fetch_pc[1:0], i_upd_pc[1:0]};

  assign fetch_idx = i_fetch_pc[INDEX_BITS+1:2];
  assign fetch_tag = i_fetch_pc[31:INDEX_BITS+2];
  assign upd_idx   = i_upd_pc[INDEX_BITS+1:2];
  assign upd_tag   = i_upd_pc[31:INDEX_BITS+2];

  // Lookup reads stored state only, so a same-cycle update is seen next cycle.
  always_comb begin
    fetch_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    o_pred_taken  = fetch_hit && (jump_q[fetch_idx] || ctr_q[fetch_idx][1]);
    o_pred_target = o_pred_taken ? target_q[fetch_idx] : '0;
  end

  always_comb begin
    upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_taken_eff = i_upd_taken || i_upd_is_jump;
    upd_write     = 1'b0;
    nxt_ctr       = ctr_q[upd_idx];
    nxt_jump      = jump_q[upd_idx];
    nxt_target    = target_q[upd_idx];
    if (i_upd_valid) begin
      if (upd_hit) begin
        upd_write = 1'b1;
        if (i_upd_is_jump) begin
          nxt_ctr    = 2'b11;
          nxt_jump   = 1'b1;
          nxt_target = i_upd_target;
        end else begin
          nxt_jump = 1'b0;
          if (i_upd_taken) begin
            nxt_ctr    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
            nxt_target = i_upd_target;
          end else begin
            nxt_ctr = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
          end
        end
      end else if (upd_taken_eff) begin
        upd_write  = 1'b1;
        nxt_ctr    = i_upd_is_jump ? 2'b11 : 2'b10;
        nxt_jump   = i_upd_is_jump;
        nxt_target = i_upd_target;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q       <= '0;
      jump_q        <= '0;
      tag_q         <= '{default: '0};
      target_q      <= '{default: '0};
      ctr_q         <= '{default: 2'b01};
      o_upd_cnt     <= '0;
      o_mispred_cnt <= '0;
    end else begin
      if (upd_write) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= nxt_target;
        jump_q[upd_idx]   <= nxt_jump;
        ctr_q[upd_idx]    <= nxt_ctr;
      end
      if (i_upd_valid) begin
        o_upd_cnt <= o_upd_cnt + CNT_WIDTH'(1);
        if (i_upd_mispred) o_mispred_cnt <= o_mispred_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
